// File: rtl/tensor_pkg.sv
// Shared types and defaults for the tensor core write-back collector.
// The entry struct matches the collector's default parameterisation.
package tensor_pkg;

   localparam int REG_W           = 5;
   localparam int TILE_ROWS_DEF   = 4;
   localparam int NUM_THREADS_DEF = 4;
   localparam int XLEN_DEF        = 32;
   localparam int NUM_WARPS_DEF   = 8;
   localparam int WID_W_DEF       = $clog2(NUM_WARPS_DEF);
   localparam int DATA_W_DEF      = NUM_THREADS_DEF * XLEN_DEF;

   typedef struct packed {
      logic [WID_W_DEF-1:0]  wid;
      logic [REG_W-1:0]      rd;
      logic [DATA_W_DEF-1:0] data;
      logic                  eop;
   } tensor_wb_entry_t;

   // Destination register of a row within a tile; wraps modulo 32.
   function automatic logic [REG_W-1:0] row_rd(input logic [REG_W-1:0] base,
                                               input logic [REG_W-1:0] row);
      return base + row;
   endfunction

endpackage

// File: rtl/tensor_wb_fifo.sv
// Synchronous FIFO of write-back rows; full/empty derived from pointers
// that carry one extra wrap bit.
module tensor_wb_fifo
   import tensor_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = tensor_wb_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t push_entry,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t         mem [DEPTH];
   logic   [AW:0]  wr_ptr;
   logic   [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are live, and the collector masks the head while empty.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/tensor_wb_collector.sv
// Collects tensor core result tiles row by row, queues them and drains one
// destination register per beat, tracking which warps have tiles in flight.
module tensor_wb_collector
   import tensor_pkg::*;
#(
   parameter int NUM_THREADS = NUM_THREADS_DEF,
   parameter int XLEN        = XLEN_DEF,
   parameter int NUM_WARPS   = NUM_WARPS_DEF,
   parameter int TILE_ROWS   = TILE_ROWS_DEF,
   parameter int DEPTH       = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(NUM_WARPS)-1:0]  in_wid,
   input  logic [REG_W-1:0]              in_rd,
   input  logic [NUM_THREADS*XLEN-1:0]   in_data,
   output logic                          commit_valid,
   input  logic                          commit_ready,
   output logic [$clog2(NUM_WARPS)-1:0]  commit_wid,
   output logic [REG_W-1:0]              commit_rd,
   output logic [NUM_THREADS*XLEN-1:0]   commit_data,
   output logic                          commit_eop,
   output logic                          release_valid,
   output logic [$clog2(NUM_WARPS)-1:0]  release_wid,
   output logic [NUM_WARPS-1:0]          warp_busy
);

   localparam int WID_W  = $clog2(NUM_WARPS);
   localparam int DATA_W = NUM_THREADS * XLEN;
   localparam int CNT_W  = $clog2(TILE_ROWS + 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TILE_ROWS - 1);

   typedef struct packed {
      logic [WID_W-1:0]  wid;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic              eop;
   } entry_t;

   typedef enum logic {IN_IDLE, IN_BURST} in_state_e;

   in_state_e          state;
   logic [CNT_W-1:0]   row_cnt;
   logic [WID_W-1:0]   wid_q;
   logic [REG_W-1:0]   rd_q;

   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               pop_eop;
   entry_t             push_entry;
   entry_t             head;
   logic [NUM_WARPS-1:0] busy_set;
   logic [NUM_WARPS-1:0] busy_clr;

   // A first row for a warp that still has a tile in flight waits, it is never dropped.
   assign in_ready     = !fifo_full && !(state == IN_IDLE && warp_busy[in_wid]);
   assign push         = in_valid && in_ready;
   assign commit_valid = !fifo_empty;
   assign pop          = commit_valid && commit_ready;
   assign pop_eop      = pop && head.eop;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value held and infer a latch.
   always_comb begin
      push_entry      = '0;
      push_entry.data = in_data;
      if (state == IN_IDLE) begin
         push_entry.wid = in_wid;
         push_entry.rd  = in_rd;
         push_entry.eop = (TILE_ROWS == 1);
      end else begin
         push_entry.wid = wid_q;
         push_entry.rd  = row_rd(rd_q, REG_W'(row_cnt));
         push_entry.eop = (row_cnt == LAST_ROW);
      end
   end

   tensor_wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Head is masked while empty so stale storage never reaches the commit stage.
   always_comb begin
      commit_wid  = '0;
      commit_rd   = '0;
      commit_data = '0;
      commit_eop  = 1'b0;
      if (!fifo_empty) begin
         commit_wid  = head.wid;
         commit_rd   = head.rd;
         commit_data = head.data;
         commit_eop  = head.eop;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IN_IDLE;
         row_cnt <= '0;
         wid_q   <= '0;
         rd_q    <= '0;
      end else if (push) begin
         if (state == IN_IDLE) begin
            wid_q <= in_wid;
            rd_q  <= in_rd;
            if (TILE_ROWS > 1) begin
               state   <= IN_BURST;
               row_cnt <= CNT_W'(1);
            end
         end else if (row_cnt == LAST_ROW) begin
            state   <= IN_IDLE;
            row_cnt <= '0;
         end else begin
            row_cnt <= row_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (push && state == IN_IDLE) begin
         busy_set[in_wid] = 1'b1;
      end
      if (pop_eop) begin
         busy_clr[head.wid] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warp_busy     <= '0;
         release_valid <= 1'b0;
         release_wid   <= '0;
      end else begin
         warp_busy     <= (warp_busy | busy_set) & ~busy_clr;
         release_valid <= pop_eop;
         if (pop_eop) begin
            release_wid <= head.wid;
         end
      end
   end

endmodule

// File: tb/tb_tensor_wb_collector.sv
// Self-checking bench for tensor_wb_collector: a directed vector table, hand
// sequences for the multi-cycle corners, and random traffic against a queue model.
module tb_tensor_wb_collector;
   import tensor_pkg::*;

   localparam int NT = 4;
   localparam int XL = 32;
   localparam int NW = 8;
   localparam int TR = 4;
   localparam int DP = 4;
   localparam int WW = 3;
   localparam int DW = NT * XL;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [WW-1:0] in_wid;
   logic [4:0]    in_rd;
   logic [DW-1:0] in_data;
   logic          commit_valid;
   logic          commit_ready;
   logic [WW-1:0] commit_wid;
   logic [4:0]    commit_rd;
   logic [DW-1:0] commit_data;
   logic          commit_eop;
   logic          release_valid;
   logic [WW-1:0] release_wid;
   logic [NW-1:0] warp_busy;

   always #5 clk = ~clk;

   tensor_wb_collector #(
      .NUM_THREADS (NT),
      .XLEN        (XL),
      .NUM_WARPS   (NW),
      .TILE_ROWS   (TR),
      .DEPTH       (DP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_wid        (in_wid),
      .in_rd         (in_rd),
      .in_data       (in_data),
      .commit_valid  (commit_valid),
      .commit_ready  (commit_ready),
      .commit_wid    (commit_wid),
      .commit_rd     (commit_rd),
      .commit_data   (commit_data),
      .commit_eop    (commit_eop),
      .release_valid (release_valid),
      .release_wid   (release_wid),
      .warp_busy     (warp_busy)
   );

   typedef struct {
      logic [WW-1:0] wid;
      logic [4:0]    rd;
      logic [DW-1:0] data;
      logic          eop;
   } row_t;

   typedef struct {
      logic          v;
      logic [WW-1:0] wid;
      logic [4:0]    rd;
      logic [DW-1:0] data;
      logic          e_ready;
      logic          e_cv;
      logic [4:0]    e_rd;
      logic [DW-1:0] e_data;
      logic          e_eop;
      logic          e_rel;
      logic          e_busy3;
   } vec_t;

   // Reference model: queued rows, busy warps, position inside the current tile.
   row_t          mq[$];
   logic [NW-1:0] m_busy;
   int            m_row;
   logic [WW-1:0] m_wid;
   logic [4:0]    m_base;
   logic          m_rel;
   logic [WW-1:0] m_rel_wid;
   int            n_acc;

   logic [4:0]    seen_rd[$];
   logic          seen_eop[$];
   logic [WW-1:0] seen_wid[$];

   int n_checks = 0;
   int n_err    = 0;

   vec_t tbl[7];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy    = '0;
      m_row     = 0;
      m_wid     = '0;
      m_base    = '0;
      m_rel     = 1'b0;
      m_rel_wid = '0;
   endtask

   task automatic clear_seen();
      seen_rd.delete();
      seen_eop.delete();
      seen_wid.delete();
   endtask

   // Called just after an edge with inputs applied: checks all outputs against
   // the model, crosses one clock edge, then advances the model.
   task automatic tick();
      logic          exp_ready;
      logic          exp_cv;
      logic          acc;
      logic          pp;
      logic [WW-1:0] s_wid;
      logic [4:0]    s_rd;
      logic [DW-1:0] s_data;
      row_t          e;
      #1;
      exp_ready = (mq.size() < DP) && !(m_row == 0 && m_busy[in_wid]);
      exp_cv    = (mq.size() != 0);
      check("in_ready", DW'(in_ready), DW'(exp_ready));
      check("commit_valid", DW'(commit_valid), DW'(exp_cv));
      if (exp_cv) begin
         e = mq[0];
         check("commit_wid", DW'(commit_wid), DW'(e.wid));
         check("commit_rd", DW'(commit_rd), DW'(e.rd));
         check("commit_data", commit_data, e.data);
         check("commit_eop", DW'(commit_eop), DW'(e.eop));
      end
      check("release_valid", DW'(release_valid), DW'(m_rel));
      if (m_rel) check("release_wid", DW'(release_wid), DW'(m_rel_wid));
      check("warp_busy", DW'(warp_busy), DW'(m_busy));
      acc    = in_valid && exp_ready;
      pp     = exp_cv && commit_ready;
      s_wid  = in_wid;
      s_rd   = in_rd;
      s_data = in_data;
      if (pp) begin
         seen_rd.push_back(commit_rd);
         seen_eop.push_back(commit_eop);
         seen_wid.push_back(commit_wid);
      end
      @(posedge clk);
      m_rel = 1'b0;
      if (pp) begin
         e = mq.pop_front();
         if (e.eop) begin
            m_busy[e.wid] = 1'b0;
            m_rel         = 1'b1;
            m_rel_wid     = e.wid;
         end
      end
      if (acc) begin
         if (m_row == 0) begin
            m_wid         = s_wid;
            m_base        = s_rd;
            m_busy[s_wid] = 1'b1;
         end
         e.wid  = m_wid;
         e.rd   = 5'((int'(m_base) + m_row) % 32);
         e.data = s_data;
         e.eop  = (m_row == TR - 1);
         mq.push_back(e);
         m_row = (m_row + 1) % TR;
         n_acc++;
      end
      #1;
   endtask

   task automatic feed_row(input logic [WW-1:0] wid, input logic [4:0] rd, input logic [DW-1:0] data);
      int start;
      start    = n_acc;
      in_valid = 1'b1;
      in_wid   = wid;
      in_rd    = rd;
      in_data  = data;
      for (int k = 0; k < 60 && n_acc == start; k++) tick();
      check("feed_accept", DW'(n_acc - start), DW'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid     = 1'b0;
      commit_ready = 1'b1;
      for (int k = 0; k < 100 && mq.size() != 0; k++) tick();
      tick();
      #1;
      check("drain_done", DW'(commit_valid), DW'(0));
   endtask

   task automatic do_reset();
      in_valid     = 1'b0;
      commit_ready = 1'b0;
      in_wid       = '0;
      in_rd        = '0;
      in_data      = '0;
      rst_n        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      clear_seen();
   endtask

   function automatic logic [DW-1:0] dpat(input int tag, input int i);
      return {4{32'(tag) + 32'(i)}};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_acc        = 0;
      in_valid     = 1'b0;
      commit_ready = 1'b0;
      in_wid       = '0;
      in_rd        = '0;
      in_data      = '0;
      rst_n        = 1'b1;
      model_reset();

      // Single tile wid 3, rd 8, commit always ready.
      for (int i = 0; i < 7; i++) begin
         tbl[i].v = (i < 4);
         tbl[i].wid = (i == 0 || i >= 4) ? 3'd3 : 3'd7;
         tbl[i].rd = (i == 0 || i >= 4) ? 5'd8 : 5'd0;
         tbl[i].data = (i < 4) ? dpat(32'hD000_0000, i) : '0;
         tbl[i].e_ready = (i != 4);
         tbl[i].e_cv = (i >= 1 && i <= 4);
         tbl[i].e_rd = 5'(8 + i - 1);
         tbl[i].e_data = dpat(32'hD000_0000, i - 1);
         tbl[i].e_eop = (i == 4);
         tbl[i].e_rel = (i == 5);
         tbl[i].e_busy3 = (i >= 1 && i <= 4);
      end

      #2 rst_n = 1'b0;
      #1;
      check("rst_commit_valid", DW'(commit_valid), DW'(0));
      check("rst_commit_wid", DW'(commit_wid), DW'(0));
      check("rst_commit_rd", DW'(commit_rd), DW'(0));
      check("rst_commit_data", commit_data, '0);
      check("rst_commit_eop", DW'(commit_eop), DW'(0));
      check("rst_release_valid", DW'(release_valid), DW'(0));
      check("rst_release_wid", DW'(release_wid), DW'(0));
      check("rst_warp_busy", DW'(warp_busy), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));
      do_reset();

      commit_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = tbl[i].v;
         in_wid   = tbl[i].wid;
         in_rd    = tbl[i].rd;
         in_data  = tbl[i].data;
         #1;
         check("tbl_in_ready", DW'(in_ready), DW'(tbl[i].e_ready));
         check("tbl_commit_valid", DW'(commit_valid), DW'(tbl[i].e_cv));
         if (tbl[i].e_cv) begin
            check("tbl_commit_wid", DW'(commit_wid), DW'(3));
            check("tbl_commit_rd", DW'(commit_rd), DW'(tbl[i].e_rd));
            check("tbl_commit_data", commit_data, tbl[i].e_data);
            check("tbl_commit_eop", DW'(commit_eop), DW'(tbl[i].e_eop));
         end
         check("tbl_release_valid", DW'(release_valid), DW'(tbl[i].e_rel));
         if (tbl[i].e_rel) check("tbl_release_wid", DW'(release_wid), DW'(3));
         check("tbl_busy3", DW'(warp_busy[3]), DW'(tbl[i].e_busy3));
         tick();
      end

      // Backpressure: fill the FIFO, hold a fifth row, then drain in order.
      do_reset();
      for (int i = 0; i < 4; i++) feed_row(3'd1, 5'd4, dpat(32'hB000_0000, i));
      in_valid = 1'b1;
      in_wid   = 3'd6;
      in_rd    = 5'd0;
      in_data  = dpat(32'hC000_0000, 0);
      #1;
      check("bp_full_ready", DW'(in_ready), DW'(0));
      tick();
      for (int k = 0; k < 2; k++) begin
         #1;
         check("bp_stall_data", commit_data, dpat(32'hB000_0000, 0));
         check("bp_stall_rd", DW'(commit_rd), DW'(4));
         tick();
      end
      commit_ready = 1'b1;
      #1;
      check("bp_no_passthru", DW'(in_ready), DW'(0));
      for (int i = 0; i < 4; i++) feed_row(3'd6, 5'd0, dpat(32'hC000_0000, i));
      drain();
      check("bp_count", DW'(seen_rd.size()), DW'(8));
      for (int i = 0; i < 8; i++)
         check("bp_order_rd", DW'(seen_rd[i]), DW'(i < 4 ? 4 + i : i - 4));

      // Busy stall: same warp blocked, other warp waits only for space.
      do_reset();
      for (int i = 0; i < 4; i++) feed_row(3'd2, 5'd16, dpat(32'h2000_0000, i));
      in_valid = 1'b1;
      in_wid   = 3'd2;
      in_rd    = 5'd0;
      #1;
      check("busy_same_warp", DW'(in_ready), DW'(0));
      tick();
      in_wid = 3'd5;
      #1;
      check("busy_full_other", DW'(in_ready), DW'(0));
      tick();
      commit_ready = 1'b1;
      feed_row(3'd5, 5'd24, dpat(32'h5000_0000, 0));
      #1;
      check("busy_both", DW'({warp_busy[5], warp_busy[2]}), DW'(2'b11));
      for (int i = 1; i < 4; i++) feed_row(3'd5, 5'd0, dpat(32'h5000_0000, i));
      drain();

      // Release of wid 2 coincides with a new first row for wid 2.
      commit_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed_row(3'd2, 5'd16, dpat(32'h2100_0000, i));
      in_valid     = 1'b1;
      in_wid       = 3'd2;
      in_rd        = 5'd1;
      in_data      = dpat(32'h2200_0000, 0);
      commit_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rel_stall", DW'(in_ready), DW'(0));
         tick();
      end
      #1;
      check("rel_pulse", DW'(release_valid), DW'(1));
      check("rel_accept_next", DW'(in_ready), DW'(1));
      tick();
      for (int i = 1; i < 4; i++) feed_row(3'd2, 5'd0, dpat(32'h2200_0000, i));
      drain();

      // Register index wrap.
      clear_seen();
      for (int i = 0; i < 4; i++) feed_row(3'd0, 5'd30, dpat(32'h3000_0000, i));
      drain();
      check("wrap_count", DW'(seen_rd.size()), DW'(4));
      for (int i = 0; i < 4; i++) begin
         check("wrap_rd", DW'(seen_rd[i]), DW'((30 + i) % 32));
         check("wrap_eop", DW'(seen_eop[i]), DW'(i == 3));
      end

      // Gaps inside a burst with wid/rd noise on the ignored inputs.
      clear_seen();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) feed_row(3'd4, 5'd12, dpat(32'h4000_0000, i));
         else feed_row(3'($urandom_range(0, 7)), 5'($urandom), dpat(32'h4000_0000, i));
         for (int g = 0; g < 1 + i % 2; g++) begin
            in_wid = 3'($urandom_range(0, 7));
            in_rd  = 5'($urandom);
            tick();
         end
      end
      drain();
      check("gap_count", DW'(seen_rd.size()), DW'(4));
      for (int i = 0; i < 4; i++) begin
         check("gap_rd", DW'(seen_rd[i]), DW'(12 + i));
         check("gap_wid", DW'(seen_wid[i]), DW'(4));
      end

      // Reset in the middle of a burst.
      commit_ready = 1'b0;
      feed_row(3'd6, 5'd20, dpat(32'h6000_0000, 0));
      feed_row(3'd6, 5'd20, dpat(32'h6000_0000, 1));
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_cv", DW'(commit_valid), DW'(0));
      check("mid_rst_rd", DW'(commit_rd), DW'(0));
      check("mid_rst_wid", DW'(commit_wid), DW'(0));
      check("mid_rst_data", commit_data, '0);
      check("mid_rst_busy", DW'(warp_busy), DW'(0));
      @(posedge clk);
      #1;
      check("mid_rst_no_release", DW'(release_valid), DW'(0));
      rst_n = 1'b1;
      model_reset();
      clear_seen();
      commit_ready = 1'b1;
      for (int i = 0; i < 4; i++) feed_row(3'd6, 5'd3, dpat(32'h6100_0000, i));
      drain();
      check("post_rst_count", DW'(seen_rd.size()), DW'(4));
      for (int i = 0; i < 4; i++) begin
         check("post_rst_rd", DW'(seen_rd[i]), DW'(3 + i));
         check("post_rst_eop", DW'(seen_eop[i]), DW'(i == 3));
      end

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         in_valid     = ($urandom_range(0, 9) < 7);
         in_wid       = 3'($urandom_range(0, 7));
         in_rd        = 5'($urandom);
         in_data      = {$urandom, $urandom, $urandom, $urandom};
         commit_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tensor_wb_collector.md
# tensor_wb_collector

Write-back collector at the output end of the tensor core. Accepts result tiles row by row from the tensor core datapath, queues them, and drains them one destination register per beat into the commit/write-back stage. Tracks per-warp outstanding tiles so the issue side knows when a warp's tensor destination registers are released.

## Interface
Parameters:
- NUM_THREADS, 4, lanes per warp; row width is NUM_THREADS*XLEN
- XLEN, 32, lane data width
- NUM_WARPS, 8, warps tracked
- TILE_ROWS, 4, rows (destination registers) per result tile, ≥1
- DEPTH, 4, row FIFO entries, power of 2, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  tensor core result row valid
- in_ready  out  1  collector can accept a row
- in_wid  in  $clog2(NUM_WARPS)  warp id, sampled on first row of tile only
- in_rd  in  5  base destination register, sampled on first row only
- in_data  in  NUM_THREADS*XLEN  row data, lane 0 in LSBs
- commit_valid  out  1  row available to commit
- commit_ready  in  1  commit stage accepts
- commit_wid  out  $clog2(NUM_WARPS)  warp of row
- commit_rd  out  5  destination register of row
- commit_data  out  NUM_THREADS*XLEN  row data
- commit_eop  out  1  last row of tile
- release_valid  out  1  one-cycle pulse: warp's tile fully committed
- release_wid  out  $clog2(NUM_WARPS)  warp released
- warp_busy  out  NUM_WARPS  warp has a tile in flight

## Operation
- Input FSM, two states. IN_IDLE: next accepted row is a first row; latch wid_q=in_wid, rd_q=in_rd, set warp_busy[in_wid], push {in_wid, in_rd, data, eop=(TILE_ROWS==1)}; go IN_BURST with row_cnt=1 unless TILE_ROWS==1.
- IN_BURST: in_wid/in_rd ignored; push {wid_q, rd_q+row_cnt (mod 32), data, eop=(row_cnt==TILE_ROWS-1)}; row_cnt++; after last row return to IN_IDLE, row_cnt=0.
- Tiles never interleave; gaps (in_valid low) inside a burst are allowed.
- in_ready = !fifo_full && !(state==IN_IDLE && warp_busy[in_wid]). New tile for a busy warp is stalled, not dropped.
- Output: commit_* driven from FIFO head; commit_valid = !fifo_empty. Pop on commit_valid && commit_ready.
- On pop with commit_eop=1: next edge clears warp_busy[commit_wid], asserts release_valid for one cycle with release_wid=commit_wid.
- No pass-through: when full, in_ready stays low even if a pop occurs that cycle.
- Simultaneous release and new first row for same warp: row not accepted that cycle (busy still set); accepted the following cycle.
- Register index wraps: rd_q=30, TILE_ROWS=4 gives rd 30,31,0,1.

## Timing
- Reset (async assert, sync deassert via rst_n): FIFO empty, FSM IN_IDLE, row_cnt=0, warp_busy=0, commit_valid=0, commit_eop=0, commit_wid/rd/data=0, release_valid=0, release_wid=0; in_ready=1 after reset when in_wid not busy.
- Reset mid-burst discards partial tile and all queued rows; no release pulse emitted.
- Latency: row accepted at edge N is on commit_* with commit_valid=1 after edge N (visible in cycle N+1).
- Throughput: one row in and one row out per cycle when not full/empty.
- commit_* stable while commit_valid && !commit_ready.
- release_valid asserted the cycle after the eop pop handshake; warp_busy bit falls at the same edge.

## Structure
- tensor_pkg: TILE_ROWS default, REG_W=5, typedef tensor_wb_entry_t {wid, rd, data, eop}.
- Sub-module tensor_wb_fifo: parameterised DEPTH synchronous FIFO of tensor_wb_entry_t, full/empty from extra-bit pointers, async active-low reset.
- Top holds input FSM, row counter, warp_busy, release logic.

## Test plan
- Single tile: wid=3, rd=8, rows D0..D3, commit_ready=1 -> commit rd 8,9,10,11 wid 3, eop only on rd 11; release_valid pulse wid 3 next cycle; warp_busy[3] high from first accept until that edge.
- Backpressure: commit_ready=0, push 4 rows -> in_ready low after 4th; 5th row held; release commit_ready -> rows drain in order, data unchanged while stalled.
- Busy stall: tile for wid 2 queued, commit_ready=0, new first row wid 2 -> in_ready=0; same with wid 5 -> accepted (after FIFO space); release of wid 2 same cycle as new row -> accepted one cycle later.
- Wrap: rd=30, TILE_ROWS=4 -> commit rd 30,31,0,1.
- Gaps: in_valid toggled inside a burst with in_wid/in_rd changing mid-burst -> rows keep first-row wid/rd sequence.
- Reset mid-burst after 2 rows -> all outputs zero immediately, warp_busy=0, no release pulse; next tile starts clean at row 0.
